activation_pipeline: RTL and testbench

- Multi-lane, pipelined successor to the single-lane activation stage. Applies one of several activation functions to LANES fixed-point values per beat.
- Supports piecewise-linear LUT interpolation, selectable from TABLES independent tables.
- Adds a valid/ready handshake with full backpressure, output saturation, and extra modes (leaky ReLU, clamp).
- Sits between the MAC accumulator output and the layer write-back buffer. LUT contents are loaded over the config write port.

---
 rtl/activation_pipeline.sv | 159 +++++++++++++++
 tb/tb_activation_pipeline.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_pipeline.sv
// rtl/activation_pipeline.sv - multi-lane 3-stage activation pipeline with PWL LUT interpolation
//
// Purpose: applies a per-beat activation function to LANES signed fixed-point
// lanes (Q_INT.Q_FRAC) with a valid/ready handshake and full backpressure.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid, in_ready   input beat handshake
//   in_x                 LANES signed lanes, lane i at [i*QW +: QW]
//   in_func, in_table    function select and LUT table select for the beat
//   out_valid, out_ready output beat handshake
//   out_fx               LANES signed results, same lane order as in_x
//   cfg_write_enable     LUT write strobe; no beat is accepted in a write cycle
//   cfg_addr, cfg_data   {table, segment} address, {a_coef, b_coef} entry
module activation_pipeline #(
  parameter int LANES      = 4,
  parameter int Q_INT      = 8,
  parameter int Q_FRAC     = 8,
  parameter int SEG_BITS   = 4,
  parameter int TABLES     = 4,
  parameter int A_INT      = 4,
  parameter int A_FRAC     = 12,
  parameter int B_INT      = 8,
  parameter int B_FRAC     = 8,
  parameter int LEAK_SHIFT = 3,
  localparam int QW = Q_INT + Q_FRAC,
  localparam int AW = A_INT + A_FRAC,
  localparam int BW = B_INT + B_FRAC,
  localparam int TB = (TABLES > 1) ? $clog2(TABLES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*QW-1:0]    in_x,
  input  logic [2:0]             in_func,
  input  logic [TB-1:0]          in_table,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*QW-1:0]    out_fx,
  input  logic                   cfg_write_enable,
  input  logic [TB+SEG_BITS-1:0] cfg_addr,
  input  logic [AW+BW-1:0]       cfg_data
);
  localparam int AB    = TB + SEG_BITS;
  localparam int DEPTH = 1 << AB;
  localparam int PW    = QW + AW;       // a*x product width
  localparam int FW    = QW + AW + 1;   // a*x + aligned b
  localparam int TW    = FW - A_FRAC;   // after dropping slope fraction bits
  localparam int BSH   = Q_FRAC + A_FRAC - B_FRAC;

  localparam logic [2:0] FN_LUT   = 3'd0;
  localparam logic [2:0] FN_ID    = 3'd1;
  localparam logic [2:0] FN_STEP  = 3'd2;
  localparam logic [2:0] FN_RELU  = 3'd3;
  localparam logic [2:0] FN_LEAKY = 3'd4;
  localparam logic [2:0] FN_CLAMP = 3'd5;

  localparam logic signed [QW-1:0] Q_MAX     = {1'b0, {(QW-1){1'b1}}};
  localparam logic signed [QW-1:0] Q_MIN     = {1'b1, {(QW-1){1'b0}}};
  localparam logic signed [QW-1:0] Q_ONE     = QW'(1) << Q_FRAC;
  localparam logic signed [QW-1:0] Q_NEG_ONE = -Q_ONE;
  // Inverting the segment MSB turns two's complement into offset binary,
  // so segment 0 holds the most negative inputs.
  localparam logic [SEG_BITS-1:0]  SEG_FLIP  = SEG_BITS'(1) << (SEG_BITS - 1);

  logic                  stall;
  logic                  accept;
  logic                  v1, v2;
  logic [AW+BW-1:0]      lut [LANES][DEPTH];  // one copy per lane read port
  logic [AB-1:0]         rd_addr [LANES];
  logic [2:0]            s1_func, s2_func;
  logic signed [QW-1:0]  s1_x [LANES];
  logic [AW+BW-1:0]      s1_coef [LANES];
  logic signed [QW-1:0]  s2_x [LANES];
  logic signed [PW-1:0]  s2_prod [LANES];
  logic signed [BW-1:0]  s2_b [LANES];
  logic [LANES*QW-1:0]   fx_next;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~reset & ~stall & ~cfg_write_enable;
  assign accept   = in_valid & in_ready;

  function automatic logic [QW-1:0] lane_eval(
    input logic [2:0]           func,
    input logic signed [QW-1:0] x,
    input logic signed [PW-1:0] prod,
    input logic signed [BW-1:0] b
  );
    logic signed [FW-1:0] full;
    logic signed [TW-1:0] t;
    logic [QW-1:0]        lut_fx;
    logic [QW-1:0]        fx;
    full = {{(FW-PW){prod[PW-1]}}, prod} + ({{(FW-BW){b[BW-1]}}, b} << BSH);
    t    = TW'(full >>> A_FRAC);  // arithmetic shift floors toward -inf
    // In range only when all bits above the result sign agree with it
    if (t[TW-1:QW-1] == '0 || t[TW-1:QW-1] == '1) lut_fx = t[QW-1:0];
    else if (t[TW-1])                             lut_fx = Q_MIN;
    else                                          lut_fx = Q_MAX;
    case (func)
      FN_LUT:   fx = lut_fx;
      FN_ID:    fx = x;
      FN_STEP:  fx = x[QW-1] ? '0 : Q_ONE;
      FN_RELU:  fx = x[QW-1] ? '0 : x;
      FN_LEAKY: fx = x[QW-1] ? (x >>> LEAK_SHIFT) : x;
      FN_CLAMP: fx = (x > Q_ONE) ? Q_ONE : ((x < Q_NEG_ONE) ? Q_NEG_ONE : x);
      default:  fx = '0;
    endcase
    return fx;
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++)
      rd_addr[l] = {in_table, in_x[l*QW+QW-SEG_BITS +: SEG_BITS] ^ SEG_FLIP};
  end

  always_comb begin
    fx_next = '0;
    for (int l = 0; l < LANES; l++)
      fx_next[l*QW +: QW] = lane_eval(s2_func, s2_x[l], s2_prod[l], s2_b[l]);
  end

  // LUT storage and datapath registers carry no reset; only valids matter.
  // The LUT read is registered with the beat, so it holds during a stall.
  always_ff @(posedge clk) begin
    if (cfg_write_enable) begin
      for (int l = 0; l < LANES; l++)
        lut[l][cfg_addr] <= cfg_data;
    end
    if (accept) begin
      s1_func <= in_func;
      for (int l = 0; l < LANES; l++) begin
        s1_x[l]    <= in_x[l*QW +: QW];
        s1_coef[l] <= lut[l][rd_addr[l]];
      end
    end
    if (!stall) begin
      s2_func <= s1_func;
      for (int l = 0; l < LANES; l++) begin
        s2_x[l]    <= s1_x[l];
        s2_prod[l] <= PW'($signed(s1_coef[l][AW+BW-1:BW])) * PW'(s1_x[l]);
        s2_b[l]    <= s1_coef[l][BW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_fx    <= '0;
    end else if (!stall) begin
      v1        <= accept;
      v2        <= v1;
      out_valid <= v2;
      if (v2) out_fx <= fx_next;
    end
  end
endmodule

// File: tb/tb_activation_pipeline.sv
// tb/tb_activation_pipeline.sv - self-checking bench for activation_pipeline
module tb_activation_pipeline;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_x;
  logic [2:0]  in_func;
  logic [1:0]  in_table;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_fx;
  logic        cfg_write_enable;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_got    = 0;
  int lut_a [4][16];
  int lut_b [4][16];
  logic [63:0] exp_q [$];

  activation_pipeline dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_func(in_func), .in_table(in_table),
    .out_valid(out_valid), .out_ready(out_ready), .out_fx(out_fx),
    .cfg_write_enable(cfg_write_enable), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input longint n, input longint d);
    if (n >= 0) return int'(n / d);
    return int'(-((-n + d - 1) / d));
  endfunction

  function automatic logic [15:0] model_lane(input int f, input int t, input int x);
    int     r;
    int     seg;
    longint full;
    case (f)
      0: begin
        seg  = (x + 32768) / 4096;
        full = longint'(lut_a[t][seg]) * longint'(x) + longint'(lut_b[t][seg]) * 4096;
        r    = floor_div(full, 4096);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
      end
      1: r = x;
      2: r = (x >= 0) ? 256 : 0;
      3: r = (x >= 0) ? x : 0;
      4: r = (x >= 0) ? x : floor_div(longint'(x), 8);
      5: r = (x > 256) ? 256 : ((x < -256) ? -256 : x);
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  function automatic logic [63:0] model_beat(input logic [2:0] f, input logic [1:0] t, input logic [63:0] xs);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 4; l++)
      r[l*16 +: 16] = model_lane(int'(f), int'(t), int'($signed(xs[l*16 +: 16])));
    return r;
  endfunction

  // One clock: sample pre-edge handshake state, advance, then check results.
  task automatic step();
    logic        xfer;
    logic        acc;
    logic        stalled;
    logic [63:0] got;
    #1;
    xfer    = out_valid && out_ready;
    acc     = in_valid && in_ready;
    stalled = out_valid && !out_ready;
    got     = out_fx;
    if (stalled) check("in_ready_stall", 64'(in_ready), 64'd0);
    if (acc) begin
      exp_q.push_back(model_beat(in_func, in_table, in_x));
      n_acc++;
    end
    if (cfg_write_enable) begin
      check("in_ready_cfg", 64'(in_ready), 64'd0);
      lut_a[cfg_addr[5:4]][cfg_addr[3:0]] = int'($signed(cfg_data[31:16]));
      lut_b[cfg_addr[5:4]][cfg_addr[3:0]] = int'($signed(cfg_data[15:0]));
    end
    @(posedge clk);
    #1;
    if (stalled) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_hold", out_fx, got);
    end
    if (xfer) begin
      n_got++;
      check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("beat_data", got, exp_q.pop_front());
    end
  endtask

  task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
    cfg_write_enable = 1'b1;
    cfg_addr         = addr;
    cfg_data         = data;
    in_valid         = 1'b1;
    in_func          = 3'd1;
    in_x             = {$urandom(), $urandom()};
    step();
    cfg_write_enable = 1'b0;
    in_valid         = 1'b0;
  endtask

  task automatic run_one(input logic [2:0] f, input logic [1:0] t, input logic [63:0] x,
                         output logic [63:0] fx, output int lat);
    in_valid = 1'b1; in_func = f; in_table = t; in_x = x; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_x     = {$urandom(), $urandom()};
    lat      = 1;
    while (!out_valid && lat < 8) begin
      step();
      lat++;
    end
    fx = out_fx;
    step();
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0; out_ready = 1'b1; cfg_write_enable = 1'b0;
    while (exp_q.size() > 0 && k < 50) begin
      step();
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] fx;
    logic [63:0] x2;
    logic [63:0] x6;
    int          lat;
    int          base_acc;
    int          base_got;
    logic [2:0]  m_fn [4];
    logic [63:0] m_ex [4];
    string       m_nm [4];

    clk = 1'b0; reset = 1'b1; in_valid = 1'b0; in_x = '0; in_func = '0; in_table = '0;
    out_ready = 1'b1; cfg_write_enable = 1'b0; cfg_addr = '0; cfg_data = '0;

    // Reset state
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_fx", out_fx, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // 1: identity with boundary values, latency
    run_one(3'd1, 2'd0, 64'h8000_7FFF_FF00_0180, fx, lat);
    check("id_latency", 64'(lat), 64'd3);
    check("id_data", fx, 64'h8000_7FFF_FF00_0180);

    // 2: elementwise modes at -1.0 and +1.5
    x2 = 64'h0180_FF00_0180_FF00;
    m_fn[0] = 3'd3; m_ex[0] = 64'h0180_0000_0180_0000; m_nm[0] = "relu";
    m_fn[1] = 3'd4; m_ex[1] = 64'h0180_FFE0_0180_FFE0; m_nm[1] = "leaky";
    m_fn[2] = 3'd2; m_ex[2] = 64'h0100_0000_0100_0000; m_nm[2] = "step";
    m_fn[3] = 3'd5; m_ex[3] = 64'h0100_FF00_0100_FF00; m_nm[3] = "clamp";
    for (int k = 0; k < 4; k++) begin
      run_one(m_fn[k], 2'd0, x2, fx, lat);
      check(m_nm[k], fx, m_ex[k]);
    end

    // 3: LUT write then interpolation (a=0.5, b=0.25, x=1.5 -> 1.0)
    cfg_write(6'd24, 32'h0800_0040);
    run_one(3'd0, 2'd1, {4{16'h0180}}, fx, lat);
    check("lut_interp", fx, {4{16'h0100}});

    // 4: saturation both ways
    cfg_write(6'd24, 32'h7000_6400);
    run_one(3'd0, 2'd1, {4{16'h0700}}, fx, lat);
    check("sat_pos", fx, {4{16'h7FFF}});
    cfg_write(6'd24, 32'h9000_9C00);
    run_one(3'd0, 2'd1, {4{16'h0700}}, fx, lat);
    check("sat_neg", fx, {4{16'h8000}});

    // 5: backpressure, 8 beats with a 5-cycle stall mid-stream
    base_acc = n_acc; base_got = n_got;
    for (int i = 0; i < 14; i++) begin
      in_valid  = (n_acc - base_acc) < 8;
      in_func   = 3'($urandom_range(1, 5));
      in_table  = 2'($urandom());
      in_x      = {$urandom(), $urandom()};
      out_ready = !(i >= 5 && i < 10);
      step();
    end
    drain();
    check("bp_sent", 64'(n_acc - base_acc), 64'd8);
    check("bp_recv", 64'(n_got - base_got), 64'd8);

    // 6: reset with three beats in flight
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_func = 3'd1;
      in_x    = {$urandom(), $urandom()};
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("no_stale_beat", 64'(out_valid), 64'd0);
    end
    x6 = {$urandom(), $urandom()};
    run_one(3'd1, 2'd0, x6, fx, lat);
    check("post_rst_latency", 64'(lat), 64'd3);
    check("post_rst_data", fx, x6);

    // Random traffic against the model, all LUT entries loaded first
    for (int a = 0; a < 64; a++) cfg_write(6'(a), $urandom());
    for (int i = 0; i < 300; i++) begin
      cfg_write_enable = ($urandom_range(0, 15) == 0);
      cfg_addr         = 6'($urandom());
      cfg_data         = $urandom();
      in_valid         = ($urandom_range(0, 3) != 0);
      in_func          = 3'($urandom_range(0, 7));
      in_table         = 2'($urandom());
      in_x             = {$urandom(), $urandom()};
      out_ready        = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
